alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 32-bit ALU between two requesters using valid/ready handshakes.
// Requests are granted round-robin. The granted request drives the ALU
// combinationally. The result, zero flag and requester id are stored in a
// one-entry output slot that supports backpressure.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req0_*  / req1_*    valid, ready, a, b, op for each requester
//   rsp_valid/rsp_ready output slot handshake
//   rsp_id              requester that produced the held result
//   rsp_result          ALU result (registered)
//   rsp_zero            result == 0 (registered)
//   op_count            accepted-operation counter, wraps at 16 bits

module alu_share_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [15:0]      op_count
);

   logic             last;
   logic             slot_free;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] alu_out;

   // A slot is free when it is empty or when it drains on this edge.
   // For a tie, the grant goes to the requester that was not granted last.
   assign slot_free  = !rsp_valid || rsp_ready;
   assign req0_ready = !rst && slot_free && req0_valid && (!req1_valid || last);
   assign req1_ready = !rst && slot_free && req1_valid && (!req0_valid || !last);
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // The operand mux follows the grant. When nothing is granted, it defaults
   // to requester 0. In that case the output is not used.
   always_comb begin
      sel_a  = req0_a;
      sel_b  = req0_b;
      sel_op = req0_op;
      if (req1_ready) begin
         sel_a  = req1_a;
         sel_b  = req1_b;
         sel_op = req1_op;
      end
   end

   always_comb begin
      alu_out = '0;
      case (sel_op)
         3'b000:  alu_out = sel_a + sel_b;
         3'b001:  alu_out = sel_a - sel_b;
         3'b010:  alu_out = sel_a & sel_b;
         3'b011:  alu_out = sel_a | sel_b;
         3'b100:  alu_out = (sel_a < sel_b) ? WIDTH'(1) : '0;
         3'b101:  alu_out = sel_a ^ sel_b;
         3'b110:  alu_out = sel_a << sel_b[4:0];
         3'b111:  alu_out = sel_a >> sel_b[4:0];
         default: alu_out = '0;
      endcase
   end

   // Reset takes priority over a simultaneous accept, so any held result
   // is discarded. If the slot drains and nothing new is accepted, the
   // slot becomes empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         op_count   <= '0;
         last       <= 1'b1;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= req1_ready;
         rsp_result <= alu_out;
         rsp_zero   <= (alu_out == '0);
         op_count   <= op_count + 16'd1;
         last       <= req1_ready;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule
